depth_stream_packer: RTL and testbench

Output stage placed directly after the last deconvolution layer. It takes the 8-bit depth pixel stream (valid plus sop/eop/sof/eof) and packs PACK_NUM pixels into one word. Words are buffered in a FIFO and presented on a valid/ready master port for the frame-writer DMA. The input side has no backpressure, so the block also checks frame geometry and flags FIFO overflow.

---
 rtl/depth_stream_packer_if.sv | 25 ++
 rtl/depth_stream_packer.sv | 185 ++++++++++++++++++
 tb/tb_depth_stream_packer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/depth_stream_packer_if.sv
// Output word stream of the depth packer toward the frame-writer DMA.
// Latency: n/a (wires only). Backpressure: consumer drives m_ready_i; producer holds the word while not ready.
// Ports: m_data_o/m_keep_o packed pixels and mask, m_valid_o/m_ready_i handshake, m_sof_o/m_eol_o/m_eof_o sideband.
interface depth_stream_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_NUM   = 4
);
  logic [DATA_WIDTH*PACK_NUM-1:0] m_data_o;
  logic [PACK_NUM-1:0]            m_keep_o;
  logic                           m_valid_o;
  logic                           m_ready_i;
  logic                           m_sof_o;
  logic                           m_eol_o;
  logic                           m_eof_o;

  modport master (
    output m_data_o, m_keep_o, m_valid_o, m_sof_o, m_eol_o, m_eof_o,
    input  m_ready_i
  );

  modport slave (
    input  m_data_o, m_keep_o, m_valid_o, m_sof_o, m_eol_o, m_eof_o,
    output m_ready_i
  );
endinterface

// File: rtl/depth_stream_packer.sv
// Packs PACK_NUM depth pixels per word, checks line/frame geometry, buffers words in a FIFO for the DMA.
// Latency: 2 cycles from the pixel that closes a word to m_valid_o on an empty FIFO.
// Backpressure: none on the pixel side; a word emitted into a full FIFO is dropped and overflow_o is set.
// Ports: clk, reset_n (async, active-low); data_i/data_valid_i/sop_i/eop_i/sof_i/eof_i pixel stream;
//        m_if (master) packed word stream; overflow_o, frame_err_o sticky flags; err_clr_i clears both.
module depth_stream_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_NUM   = 4,
  parameter int STRING_LEN = 224,
  parameter int STRING_NUM = 224,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic                  sof_i,
  input  logic                  eof_i,
  depth_stream_packer_if.master m_if,
  output logic                  overflow_o,
  output logic                  frame_err_o,
  input  logic                  err_clr_i
);
  localparam int WW = DATA_WIDTH * PACK_NUM;
  localparam int FW = WW + PACK_NUM + 3;
  localparam int IW = $clog2(PACK_NUM);
  localparam int PW = $clog2(STRING_LEN + 1);
  localparam int LW = $clog2(STRING_NUM + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [IW-1:0] LAST_SLOT = IW'(PACK_NUM - 1);
  localparam logic [PW-1:0] LAST_PIX  = PW'(STRING_LEN - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(STRING_NUM - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t          r_state;
  logic [WW-1:0]   r_acc_data;
  logic [PACK_NUM-1:0] r_acc_keep;
  logic            r_acc_sof;
  logic [IW-1:0]   r_pack_idx;
  logic [PW-1:0]   r_pix_cnt;
  logic [LW-1:0]   r_line_cnt;
  logic [FW-1:0]   r_word;      // {sof, eol, eof, keep, data}
  logic            r_word_vld;
  logic [FW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_overflow;
  logic            r_frame_err;

  logic            w_pix;
  logic [IW-1:0]   w_slot;
  logic [PW-1:0]   w_pcnt;
  logic [LW-1:0]   w_lcnt;
  logic [WW-1:0]   w_data;
  logic [PACK_NUM-1:0] w_keep;
  logic            w_sof_flag;
  logic            w_len_hit;
  logic            w_eol;
  logic            w_close;
  logic            w_err;
  logic            w_full;
  logic            w_wr;
  logic            w_rd;
  logic            w_drop;
  logic [FW-1:0]   w_out;
  logic            w_unused;

  // Line starts are tracked by the pixel counter, so sop_i carries no extra information here.
  assign w_unused = sop_i;

  // A sof pixel is accepted in either state; in ACTIVE it restarts the frame and discards the partial word.
  assign w_pix      = data_valid_i && (r_state == ACTIVE || sof_i);
  assign w_slot     = sof_i ? '0 : r_pack_idx;
  assign w_pcnt     = sof_i ? '0 : r_pix_cnt;
  assign w_lcnt     = sof_i ? '0 : r_line_cnt;
  assign w_sof_flag = sof_i || r_acc_sof;
  assign w_len_hit  = (w_pcnt == LAST_PIX);
  // A full-length line closes the word as end-of-line even when eop_i is missing.
  assign w_eol      = eop_i || w_len_hit;
  assign w_close    = w_pix && (w_slot == LAST_SLOT || w_eol || eof_i);
  assign w_err      = w_pix && ((eop_i != w_len_hit) ||
                                (eof_i && (!eop_i || w_lcnt != LAST_LINE)) ||
                                (sof_i && r_state == ACTIVE));

  always_comb begin
    w_data = sof_i ? '0 : r_acc_data;
    w_keep = sof_i ? '0 : r_acc_keep;
    for (int i = 0; i < PACK_NUM; i++) begin
      if (w_slot == IW'(i)) begin
        w_data[i*DATA_WIDTH +: DATA_WIDTH] = data_i;
        w_keep[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= WAIT_SOF;
      r_acc_data <= '0;
      r_acc_keep <= '0;
      r_acc_sof  <= 1'b0;
      r_pack_idx <= '0;
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
      r_word     <= '0;
      r_word_vld <= 1'b0;
    end else begin
      r_word_vld <= 1'b0;
      if (w_pix) begin
        r_state <= eof_i ? WAIT_SOF : ACTIVE;
        if (w_eol) begin
          r_pix_cnt  <= '0;
          r_line_cnt <= w_lcnt + LW'(1);
        end else begin
          r_pix_cnt  <= w_pcnt + PW'(1);
          r_line_cnt <= w_lcnt;
        end
        if (w_close) begin
          r_word     <= {w_sof_flag, w_eol, eof_i, w_keep, w_data};
          r_word_vld <= 1'b1;
          r_acc_data <= '0;
          r_acc_keep <= '0;
          r_acc_sof  <= 1'b0;
          r_pack_idx <= '0;
        end else begin
          r_acc_data <= w_data;
          r_acc_keep <= w_keep;
          r_acc_sof  <= w_sof_flag;
          r_pack_idx <= w_slot + IW'(1);
        end
      end
    end
  end

  // Fullness is judged before the same-cycle read, so a read never makes room for a dropped word.
  assign w_full = (r_cnt == DEPTH_C);
  assign w_rd   = (r_cnt != '0) && m_if.m_ready_i;
  assign w_wr   = r_word_vld && !w_full;
  assign w_drop = r_word_vld && w_full;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      // A new error in the clearing cycle keeps the flag set.
      if (w_drop)         r_overflow <= 1'b1;
      else if (err_clr_i) r_overflow <= 1'b0;
      if (w_err)          r_frame_err <= 1'b1;
      else if (err_clr_i) r_frame_err <= 1'b0;
    end
  end

  // Memory is not reset; gating by occupancy keeps the outputs at zero when empty or in reset.
  assign w_out = (r_cnt != '0) ? r_mem[r_rd_ptr] : '0;

  assign m_if.m_valid_o = (r_cnt != '0);
  assign m_if.m_data_o  = w_out[WW-1:0];
  assign m_if.m_keep_o  = w_out[WW +: PACK_NUM];
  assign m_if.m_eof_o   = w_out[FW-3];
  assign m_if.m_eol_o   = w_out[FW-2];
  assign m_if.m_sof_o   = w_out[FW-1];
  assign overflow_o     = r_overflow;
  assign frame_err_o    = r_frame_err;
endmodule

// File: tb/tb_depth_stream_packer.sv
// Directed bench for depth_stream_packer: frame packing, partial words, geometry errors, overflow, reset.
// Instance a: 8x8 frames, FIFO depth 8. Instance b: 6-pixel lines, 2 lines, FIFO depth 4.
// Both instances see the same pixel stream; each scenario checks only the instance it targets.
module tb_depth_stream_packer;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       err_clr;
  logic [7:0] pix;
  logic       pv, sop, eop, sof, eof;
  logic       ovf_a, ferr_a, ovf_b, ferr_b;

  int checks = 0;
  int errors = 0;

  logic [38:0] q_a[$];
  logic [38:0] q_b[$];

  always #5 clk = ~clk;

  depth_stream_packer_if #(.DATA_WIDTH(8), .PACK_NUM(4)) if_a ();
  depth_stream_packer_if #(.DATA_WIDTH(8), .PACK_NUM(4)) if_b ();

  depth_stream_packer #(.DATA_WIDTH(8), .PACK_NUM(4), .STRING_LEN(8), .STRING_NUM(8), .FIFO_DEPTH(8)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .data_i(pix), .data_valid_i(pv), .sop_i(sop), .eop_i(eop),
    .sof_i(sof), .eof_i(eof), .m_if(if_a.master), .overflow_o(ovf_a), .frame_err_o(ferr_a),
    .err_clr_i(err_clr)
  );

  depth_stream_packer #(.DATA_WIDTH(8), .PACK_NUM(4), .STRING_LEN(6), .STRING_NUM(2), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .data_i(pix), .data_valid_i(pv), .sop_i(sop), .eop_i(eop),
    .sof_i(sof), .eof_i(eof), .m_if(if_b.master), .overflow_o(ovf_b), .frame_err_o(ferr_b),
    .err_clr_i(err_clr)
  );

  // Record every accepted word; sampled after the falling edge so the next rising edge completes the handshake.
  always begin
    @(negedge clk);
    #1;
    if (if_a.m_valid_o && if_a.m_ready_i)
      q_a.push_back({if_a.m_sof_o, if_a.m_eol_o, if_a.m_eof_o, if_a.m_keep_o, if_a.m_data_o});
    if (if_b.m_valid_o && if_b.m_ready_i)
      q_b.push_back({if_b.m_sof_o, if_b.m_eol_o, if_b.m_eof_o, if_b.m_keep_o, if_b.m_data_o});
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [38:0] mk(input logic s, input logic e, input logic f,
                                     input logic [3:0] k, input logic [31:0] d);
    return {s, e, f, k, d};
  endfunction

  function automatic logic [31:0] seq4(input int b);
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  task automatic px(input logic [7:0] d, input logic so, input logic eo, input logic fs, input logic fe);
    @(negedge clk);
    pix = d; pv = 1'b1; sop = so; eop = eo; sof = fs; eof = fe;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pv = 1'b0; sop = 1'b0; eop = 1'b0; sof = 1'b0; eof = 1'b0; pix = 8'h00;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    pv = 1'b0; sop = 1'b0; eop = 1'b0; sof = 1'b0; eof = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q_a.delete();
    q_b.delete();
  endtask

  initial begin
    reset_n = 1'b0; err_clr = 1'b0;
    pix = 8'h00; pv = 1'b0; sop = 1'b0; eop = 1'b0; sof = 1'b0; eof = 1'b0;
    if_a.m_ready_i = 1'b1;
    if_b.m_ready_i = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_valid", if_a.m_valid_o, 0);
    chk("rst_word", {if_a.m_sof_o, if_a.m_eol_o, if_a.m_eof_o, if_a.m_keep_o, if_a.m_data_o}, 0);
    chk("rst_flags", {ovf_a, ferr_a}, 0);
    reset_n = 1'b1;
    q_a.delete(); q_b.delete();

    // Full 8x8 frame, consumer always ready
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < 8; c++)
        px(8'(l * 8 + c + 1), c == 0, c == 7, (l == 0) && (c == 0), (l == 7) && (c == 7));
    idle(8);
    chk("frame_count", q_a.size(), 16);
    for (int j = 0; j < 16; j++)
      chk($sformatf("frame_word%0d", j), q_a[j],
          mk(j == 0, (j % 2) == 1, j == 15, 4'hF, seq4((j / 2) * 8 + (j % 2) * 4 + 1)));
    chk("frame_flags", {ovf_a, ferr_a}, 0);

    // Six-pixel line: full word, then a two-pixel end-of-line word; also 2-cycle latency
    do_reset();
    px(8'h01, 1, 0, 1, 0);
    px(8'h02, 0, 0, 0, 0);
    px(8'h03, 0, 0, 0, 0);
    px(8'h04, 0, 0, 0, 0);
    idle(1);
    chk("lat_edge_n", if_b.m_valid_o, 0);
    idle(1);
    chk("lat_edge_n1", if_b.m_valid_o, 1);
    chk("lat_data", if_b.m_data_o, 32'h04030201);
    px(8'h05, 0, 0, 0, 0);
    px(8'h06, 0, 1, 0, 0);
    idle(8);
    chk("short_count", q_b.size(), 2);
    chk("short_word0", q_b[0], mk(1, 0, 0, 4'hF, 32'h04030201));
    chk("short_word1", q_b[1], mk(0, 1, 0, 4'h3, 32'h00000605));
    chk("short_flags", {ovf_b, ferr_b}, 0);

    // Early eop at pixel 5 of an 8-pixel line
    do_reset();
    px(8'h01, 1, 0, 1, 0);
    px(8'h02, 0, 0, 0, 0);
    px(8'h03, 0, 0, 0, 0);
    px(8'h04, 0, 0, 0, 0);
    px(8'h05, 0, 1, 0, 0);
    chk("eop_err_before", ferr_a, 0);
    idle(1);
    chk("eop_err_after", ferr_a, 1);
    idle(6);
    chk("eop_count", q_a.size(), 2);
    chk("eop_word0", q_a[0], mk(1, 0, 0, 4'hF, 32'h04030201));
    chk("eop_word1", q_a[1], mk(0, 1, 0, 4'h1, 32'h00000005));
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("err_clear", ferr_a, 0);

    // Overflow: ten words into an eight-deep FIFO with the consumer stalled
    do_reset();
    if_a.m_ready_i = 1'b0;
    for (int i = 0; i < 40; i++)
      px(8'(i + 1), (i % 8) == 0, (i % 8) == 7, i == 0, 0);
    idle(6);
    chk("ovf_valid", if_a.m_valid_o, 1);
    chk("ovf_flag", ovf_a, 1);
    chk("ovf_held", q_a.size(), 0);
    chk("ovf_head", if_a.m_data_o, 32'h04030201);
    @(negedge clk);
    if_a.m_ready_i = 1'b1;
    repeat (12) @(negedge clk);
    chk("drain_count", q_a.size(), 8);
    for (int j = 0; j < 8; j++)
      chk($sformatf("drain_word%0d", j), q_a[j], mk(j == 0, (j % 2) == 1, 0, 4'hF, seq4(j * 4 + 1)));
    chk("drain_valid", if_a.m_valid_o, 0);
    chk("drain_ferr", ferr_a, 0);

    // Pixels before sof are ignored; a second sof restarts the frame
    do_reset();
    px(8'hA1, 0, 0, 0, 0);
    px(8'hA2, 0, 0, 0, 0);
    px(8'hA3, 0, 0, 0, 0);
    idle(4);
    chk("presof_none", q_a.size(), 0);
    chk("presof_valid", if_a.m_valid_o, 0);
    px(8'h11, 1, 0, 1, 0);
    px(8'h12, 0, 0, 0, 0);
    idle(2);
    chk("restart_err_pre", ferr_a, 0);
    px(8'h21, 1, 0, 1, 0);
    px(8'h22, 0, 0, 0, 0);
    px(8'h23, 0, 0, 0, 0);
    px(8'h24, 0, 0, 0, 0);
    idle(1);
    chk("restart_err", ferr_a, 1);
    idle(6);
    chk("restart_count", q_a.size(), 1);
    chk("restart_word", q_a[0], mk(1, 0, 0, 4'hF, 32'h24232221));

    // Reset mid-frame with three words queued and a partial word pending
    do_reset();
    if_a.m_ready_i = 1'b0;
    for (int i = 0; i < 14; i++)
      px(8'(8'h40 + i), (i % 8) == 0, (i % 8) == 7, i == 0, 0);
    idle(4);
    chk("midrst_queued", if_a.m_valid_o, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", if_a.m_valid_o, 0);
    chk("midrst_word", {if_a.m_sof_o, if_a.m_eol_o, if_a.m_eof_o, if_a.m_keep_o, if_a.m_data_o}, 0);
    if_a.m_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q_a.delete(); q_b.delete();
    chk("midrst_flags", {ovf_a, ferr_a}, 0);
    px(8'h31, 1, 0, 1, 0);
    px(8'h32, 0, 0, 0, 0);
    px(8'h33, 0, 0, 0, 0);
    px(8'h34, 0, 0, 0, 0);
    idle(6);
    chk("midrst_count", q_a.size(), 1);
    chk("midrst_first", q_a[0], mk(1, 0, 0, 4'hF, 32'h34333231));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
